// File: rtl/wishbone_arbiter_if.sv
// Shared downstream Wishbone bus between the arbiter (master side) and the interconnect (slave side).
interface wishbone_interface;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [31:0] adr;
  logic [3:0]  sel;
  logic [31:0] dat_mosi;
  logic [31:0] dat_miso;
  logic        ack;
  logic        err;

  modport master (output cyc, stb, we, adr, sel, dat_mosi, input dat_miso, ack, err);
  modport slave  (input cyc, stb, we, adr, sel, dat_mosi, output dat_miso, ack, err);
endinterface

// File: rtl/wishbone_arbiter.sv
// Round-robin arbiter sharing one Wishbone slave port between NUM_MASTERS masters,
// holding the grant for a whole cyc and aborting stalled strobes with err.
module wishbone_arbiter #(
  parameter int unsigned NUM_MASTERS = 2,
  parameter int unsigned TIMEOUT     = 255
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_MASTERS-1:0]     m_cyc,
  input  logic [NUM_MASTERS-1:0]     m_stb,
  input  logic [NUM_MASTERS-1:0]     m_we,
  input  logic [32*NUM_MASTERS-1:0]  m_adr,
  input  logic [4*NUM_MASTERS-1:0]   m_sel,
  input  logic [32*NUM_MASTERS-1:0]  m_dat_mosi,
  output logic [32*NUM_MASTERS-1:0]  m_dat_miso,
  output logic [NUM_MASTERS-1:0]     m_ack,
  output logic [NUM_MASTERS-1:0]     m_err,
  output logic [NUM_MASTERS-1:0]     grant,
  wishbone_interface.master          wishbone
);

  localparam int unsigned PTR_W  = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int unsigned TO_W   = $clog2(TIMEOUT + 1);
  localparam int unsigned WD_W   = (TO_W > 8) ? TO_W : 8;

  typedef enum logic [1:0] {IDLE, BUSY, ABORT} state_t;

  state_t                 state, state_n;
  logic [NUM_MASTERS-1:0] grant_n;
  logic [PTR_W-1:0]       rr_ptr, rr_ptr_n;
  logic [WD_W-1:0]        wd_cnt, wd_n;
  logic [PTR_W-1:0]       owner;
  logic [PTR_W-1:0]       pick;
  logic [PTR_W-1:0]       cand;
  logic                   pick_valid;

  // Index of the current one-hot owner.
  always_comb begin
    owner = '0;
    for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
      if (grant[i]) owner = PTR_W'(i);
    end
  end

  // First requesting master searching upward from rr_ptr with wrap-around.
  always_comb begin
    pick       = '0;
    pick_valid = 1'b0;
    cand       = '0;
    for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
      cand = PTR_W'((32'(rr_ptr) + i) % NUM_MASTERS);
      if (!pick_valid && m_cyc[cand]) begin
        pick       = cand;
        pick_valid = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      grant  <= '0;
      rr_ptr <= '0;
      wd_cnt <= '0;
    end else begin
      state  <= state_n;
      grant  <= grant_n;
      rr_ptr <= rr_ptr_n;
      wd_cnt <= wd_n;
    end
  end

  // Next state and combinational routing between the owner and the shared bus.
  always_comb begin
    state_n           = state;
    grant_n           = grant;
    rr_ptr_n          = rr_ptr;
    wd_n              = wd_cnt;
    wishbone.cyc      = 1'b0;
    wishbone.stb      = 1'b0;
    wishbone.we       = 1'b0;
    wishbone.adr      = '0;
    wishbone.sel      = '0;
    wishbone.dat_mosi = '0;
    m_ack             = '0;
    m_err             = '0;
    m_dat_miso        = '0;

    unique case (state)
      IDLE: begin
        wd_n = '0;
        if (pick_valid) begin
          grant_n = NUM_MASTERS'(1) << pick;
          state_n = BUSY;
        end
      end

      BUSY: begin
        m_ack[owner]                 = wishbone.ack;
        m_err[owner]                 = wishbone.err;
        m_dat_miso[32*owner +: 32]   = wishbone.dat_miso;
        if (!m_cyc[owner]) begin
          // Release: one dead cycle before the next owner is chosen.
          grant_n  = '0;
          rr_ptr_n = PTR_W'((32'(owner) + 1) % NUM_MASTERS);
          wd_n     = '0;
          state_n  = IDLE;
        end else begin
          wishbone.cyc      = 1'b1;
          wishbone.stb      = m_stb[owner];
          wishbone.we       = m_we[owner];
          wishbone.adr      = m_adr[32*owner +: 32];
          wishbone.sel      = m_sel[4*owner +: 4];
          wishbone.dat_mosi = m_dat_mosi[32*owner +: 32];
          if (m_stb[owner] && !wishbone.ack && !wishbone.err) begin
            if (TIMEOUT != 0 && wd_cnt == WD_W'(TIMEOUT - 1)) begin
              wd_n    = '0;
              state_n = ABORT;
            end else begin
              wd_n = wd_cnt + WD_W'(1);
            end
          end else begin
            wd_n = '0;
          end
        end
      end

      ABORT: begin
        m_err[owner] = 1'b1;
        wd_n         = '0;
        state_n      = BUSY;
      end

      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_wishbone_arbiter.sv
// Directed and randomized checks of wishbone_arbiter against a cycle-level reference model.
module tb_wishbone_arbiter;
  localparam int unsigned N  = 2;
  localparam int unsigned TO = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    m_cyc, m_stb, m_we;
  logic [32*N-1:0] m_adr, m_dat_mosi;
  logic [4*N-1:0]  m_sel;
  logic [32*N-1:0] m_dat_miso, nt_dat_miso;
  logic [N-1:0]    m_ack, m_err, grant, nt_ack, nt_err, nt_grant;

  int checks = 0;
  int errors = 0;

  // Reference model state: owner index (-1 = nobody), pointer, unanswered strobe cycles, abort flag.
  int owner, ptr, waitc;
  bit abrt;

  logic [31:0] wlog[$];
  logic [31:0] wdat[3];
  logic        stb_h[12], cyc_h[12];
  logic [N-1:0] err_h[12];
  int          nt_stb_cnt;

  wishbone_interface bus();
  wishbone_interface bus_nt();

  wishbone_arbiter #(.NUM_MASTERS(N), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we), .m_adr(m_adr),
    .m_sel(m_sel), .m_dat_mosi(m_dat_mosi), .m_dat_miso(m_dat_miso), .m_ack(m_ack),
    .m_err(m_err), .grant(grant), .wishbone(bus));

  wishbone_arbiter #(.NUM_MASTERS(N), .TIMEOUT(0)) dut_nt (
    .clk(clk), .rst(rst), .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we), .m_adr(m_adr),
    .m_sel(m_sel), .m_dat_mosi(m_dat_mosi), .m_dat_miso(nt_dat_miso), .m_ack(nt_ack),
    .m_err(nt_err), .grant(nt_grant), .wishbone(bus_nt));

  always #5 clk = ~clk;

  // Writes actually accepted by the slave.
  always @(posedge clk) begin
    if (bus.cyc && bus.stb && bus.we && bus.ack) wlog.push_back(bus.dat_mosi);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    owner = -1; ptr = 0; waitc = 0; abrt = 0;
  endtask

  task automatic model_check();
    logic [N-1:0]    eg, ea, ee;
    logic [32*N-1:0] ed;
    eg = '0; ea = '0; ee = '0; ed = '0;
    if (owner >= 0) begin
      eg[owner] = 1'b1;
      if (abrt) ee[owner] = 1'b1;
      else begin
        ea[owner] = bus.ack;
        ee[owner] = bus.err;
        ed[owner*32 +: 32] = bus.dat_miso;
      end
    end
    chk("grant", 64'(grant), 64'(eg));
    chk("m_ack", 64'(m_ack), 64'(ea));
    chk("m_err", 64'(m_err), 64'(ee));
    chk("m_dat_miso", 64'(m_dat_miso), 64'(ed));
    if (owner < 0) begin
      chk("idle_cyc", 64'(bus.cyc), 64'd0);
      chk("idle_stb", 64'(bus.stb), 64'd0);
      chk("idle_we", 64'(bus.we), 64'd0);
      chk("idle_adr", 64'(bus.adr), 64'd0);
      chk("idle_sel", 64'(bus.sel), 64'd0);
      chk("idle_dat", 64'(bus.dat_mosi), 64'd0);
    end else if (abrt || !m_cyc[owner]) begin
      chk("dead_cyc", 64'(bus.cyc), 64'd0);
      chk("dead_stb", 64'(bus.stb), 64'd0);
    end else begin
      chk("busy_cyc", 64'(bus.cyc), 64'd1);
      chk("busy_stb", 64'(bus.stb), 64'(m_stb[owner]));
      chk("busy_we", 64'(bus.we), 64'(m_we[owner]));
      chk("busy_adr", 64'(bus.adr), 64'(m_adr[owner*32 +: 32]));
      chk("busy_sel", 64'(bus.sel), 64'(m_sel[owner*4 +: 4]));
      chk("busy_dat", 64'(bus.dat_mosi), 64'(m_dat_mosi[owner*32 +: 32]));
    end
  endtask

  task automatic model_next();
    if (owner < 0) begin
      for (int k = 0; k < N; k++) begin
        int c;
        c = (ptr + k) % N;
        if (owner < 0 && m_cyc[c]) owner = c;
      end
      waitc = 0;
    end else if (abrt) begin
      abrt = 0; waitc = 0;
    end else if (!m_cyc[owner]) begin
      ptr = (owner + 1) % N; owner = -1; waitc = 0;
    end else if (m_stb[owner] && !bus.ack && !bus.err) begin
      waitc++;
      if (TO != 0 && waitc == TO) begin abrt = 1; waitc = 0; end
    end else begin
      waitc = 0;
    end
  endtask

  // One clock: check at the falling edge, advance the model at the rising edge.
  task automatic step();
    @(negedge clk);
    model_check();
    @(posedge clk);
    model_next();
    #1;
  endtask

  initial begin
    rst = 1'b0;
    m_cyc = '0; m_stb = '0; m_we = '0; m_adr = '0; m_sel = '0; m_dat_mosi = '0;
    bus.ack = 1'b0; bus.err = 1'b0; bus.dat_miso = '0;
    bus_nt.ack = 1'b0; bus_nt.err = 1'b0; bus_nt.dat_miso = '0;
    wdat = '{32'h11, 32'h22, 32'h33};
    model_reset();
    #3;
    chk("rst_grant", 64'(grant), 64'd0);
    chk("rst_cyc", 64'(bus.cyc), 64'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    step();

    // Simultaneous request, M0 read.
    m_cyc = 2'b11; m_stb = 2'b11; m_sel = 8'hFF;
    m_adr = {32'h2000_0000, 32'h1000_0000};
    step();
    chk("t1_grant", 64'(grant), 64'h1);
    bus.ack = 1'b1; bus.dat_miso = 32'h0000_A5A5;
    #1;
    chk("t1_adr", 64'(bus.adr), 64'h1000_0000);
    chk("t1_miso0", 64'(m_dat_miso[31:0]), 64'h0000_A5A5);
    chk("t1_miso1", 64'(m_dat_miso[63:32]), 64'd0);
    chk("t1_ack", 64'(m_ack), 64'h1);
    step();
    bus.ack = 1'b0; m_cyc = 2'b10; m_stb = 2'b10;
    step(); step();
    chk("t1_regrant", 64'(grant), 64'h2);

    // M1 back-to-back writes while M0 keeps requesting.
    wlog.delete();
    m_cyc = 2'b11; m_stb = 2'b11; m_we = 2'b10;
    for (int k = 0; k < 3; k++) begin
      m_dat_mosi[63:32] = wdat[k]; bus.ack = 1'b1;
      #1;
      chk("t2_m0_noack", 64'(m_ack[0]), 64'd0);
      step();
    end
    chk("t2_count", 64'(wlog.size()), 64'd3);
    for (int k = 0; k < 3; k++) begin
      if (k < wlog.size()) chk("t2_order", 64'(wlog[k]), 64'(wdat[k]));
    end
    bus.ack = 1'b0; m_cyc = 2'b01; m_stb = 2'b01; m_we = '0;
    step(); step();
    chk("t2_m0_grant", 64'(grant), 64'h1);

    // Silent slave: watchdog on the TIMEOUT=4 instance, none on TIMEOUT=0.
    nt_stb_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      #1;
      stb_h[i] = bus.stb; cyc_h[i] = bus.cyc; err_h[i] = m_err;
      if (bus_nt.stb) nt_stb_cnt++;
      step();
    end
    for (int i = 0; i < 4; i++) chk("t3_stb_high", 64'(stb_h[i]), 64'd1);
    chk("t3_abort_cyc", 64'(cyc_h[4]), 64'd0);
    chk("t3_abort_err", 64'(err_h[4]), 64'h1);
    chk("t3_retry_stb", 64'(stb_h[5]), 64'd1);
    chk("t3_no_wd", 64'(nt_stb_cnt), 64'd12);
    m_cyc = '0; m_stb = '0;
    step(); step();

    // Ack on the last cycle before expiry wins.
    m_cyc = 2'b01; m_stb = 2'b01;
    step();
    for (int k = 0; k < 3; k++) step();
    bus.ack = 1'b1;
    #1;
    chk("t4_ack", 64'(m_ack), 64'h1);
    chk("t4_err", 64'(m_err), 64'd0);
    step();
    bus.ack = 1'b0; m_stb = 2'b00;
    #1;
    chk("t4_noabort_cyc", 64'(bus.cyc), 64'd1);
    chk("t4_noabort_err", 64'(m_err), 64'd0);
    step();
    m_cyc = '0;
    step(); step();

    // Slave error goes only to the owner (M1, pointer now 1).
    m_cyc = 2'b11; m_stb = 2'b10; m_adr[63:32] = 32'hDEAD_0000;
    step();
    bus.err = 1'b1;
    #1;
    chk("t5_err", 64'(m_err), 64'h2);
    chk("t5_ack", 64'(m_ack), 64'd0);
    step();
    bus.err = 1'b0; m_stb = '0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("t5_hold", 64'(grant), 64'h2);
    end
    m_cyc = '0;
    step(); step();

    // Stray responses while idle are dropped.
    bus.ack = 1'b1; bus.err = 1'b1;
    #1;
    chk("t6_ack", 64'(m_ack), 64'd0);
    chk("t6_err", 64'(m_err), 64'd0);
    step(); step();
    bus.ack = 1'b0; bus.err = 1'b0;

    // Asynchronous reset mid-transfer.
    m_cyc = 2'b01; m_stb = 2'b01;
    step(); step();
    bus.ack = 1'b1;
    #2; rst = 1'b0; #1;
    chk("t7_grant", 64'(grant), 64'd0);
    chk("t7_cyc", 64'(bus.cyc), 64'd0);
    chk("t7_ack", 64'(m_ack), 64'd0);
    chk("t7_err", 64'(m_err), 64'd0);
    model_reset();
    m_cyc = '0; m_stb = '0; bus.ack = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    m_cyc = 2'b01; m_stb = 2'b01;
    step();
    chk("t7_regrant", 64'(grant), 64'h1);
    m_cyc = '0; m_stb = '0;
    step(); step();

    // Randomized traffic against the model.
    for (int r = 0; r < 600; r++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 5) == 0) m_cyc[i] = ~m_cyc[i];
        m_stb[i] = ($urandom_range(0, 3) != 0);
        m_we[i]  = 1'($urandom);
      end
      m_adr = {$urandom, $urandom};
      m_dat_mosi = {$urandom, $urandom};
      m_sel = 8'($urandom);
      bus.ack = ($urandom_range(0, 3) == 0);
      bus.err = !bus.ack && ($urandom_range(0, 15) == 0);
      bus.dat_miso = $urandom;
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
